// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, i_mem control bits
// and the dump FSM state type.
package mips_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int MEM_RD_BIT = 0;
   localparam int MEM_WR_BIT = 1;

   typedef logic [1:0] dump_state_t;
   localparam dump_state_t ST_IDLE = 2'd0;
   localparam dump_state_t ST_READ = 2'd1;
   localparam dump_state_t ST_SEND = 2'd2;
   localparam dump_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mem_stage_dmem_if.sv
// Bundle of EX/MEM-side access signals and the debug dump stream for mem_stage_dmem.
interface mem_stage_dmem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
);
   logic                  i_start;
   logic                  i_step;
   logic [DATA_WIDTH-1:0] i_aluresult;
   logic [DATA_WIDTH-1:0] i_regB;
   logic [2:0]            i_mem;
   logic [1:0]            i_sizemem;
   logic                  i_signedmem;
   logic [DATA_WIDTH-1:0] o_read_data;
   logic                  o_misaligned;
   logic                  o_busy;
   logic                  i_dump_req;
   logic                  i_dump_ready;
   logic                  o_dump_valid;
   logic [ADDR_WIDTH-1:0] o_dump_addr;
   logic [DATA_WIDTH-1:0] o_dump_data;
   logic                  o_dump_done;

   modport slave (
      input  i_start, i_step, i_aluresult, i_regB, i_mem, i_sizemem, i_signedmem,
      input  i_dump_req, i_dump_ready,
      output o_read_data, o_misaligned, o_busy,
      output o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
   );

   modport master (
      output i_start, i_step, i_aluresult, i_regB, i_mem, i_sizemem, i_signedmem,
      output i_dump_req, i_dump_ready,
      input  o_read_data, o_misaligned, o_busy,
      input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
   );
endinterface

// File: rtl/dmem_ram.sv
// Byte-enabled data RAM: async-read/sync-write pipeline port plus a
// registered read port used by the debug dump.
module dmem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_we,
   input  logic [DATA_WIDTH/8-1:0] i_be,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   input  logic                    i_dump_en,
   input  logic [ADDR_WIDTH-1:0]   i_dump_addr,
   output logic [DATA_WIDTH-1:0]   o_dump_data
);
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_dump_data;

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

   // Only the dump output register is reset; the array keeps its contents.
   always_ff @(posedge i_clock) begin
      if (i_reset)        r_dump_data <= '0;
      else if (i_dump_en) r_dump_data <= r_mem[i_dump_addr];
   end

   assign o_dump_data = r_dump_data;
endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: sized/extended loads and lane-masked stores, plus a debug RAM dump.
// Optional build macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module mem_stage_dmem
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic             i_clock,
   input  logic             i_reset,
   mem_stage_dmem_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   dump_state_t           r_state;
   logic [ADDR_WIDTH-1:0] r_dump_addr;
   logic                  w_busy;
   logic [ADDR_WIDTH-1:0] w_widx;
   logic [1:0]            w_lane_raw;
   logic [1:0]            w_lane;
   logic                  w_is_byte;
   logic                  w_is_half;
   logic                  w_misal;
   logic                  w_access;
   logic                  w_we;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] w_ext;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic                  w_unused;

   assign w_widx     = bus.i_aluresult[ADDR_WIDTH+1:2];
   assign w_lane_raw = bus.i_aluresult[1:0];
   assign w_is_byte  = (bus.i_sizemem == SIZE_BYTE);
   assign w_is_half  = (bus.i_sizemem == SIZE_HALF);
   assign w_access   = bus.i_start && bus.i_step && (|bus.i_mem[MEM_WR_BIT:MEM_RD_BIT]);
   assign w_unused   = ^{bus.i_mem[2], bus.i_aluresult[DATA_WIDTH-1:ADDR_WIDTH+2], w_access};

`ifdef DMEM_MISALIGN_TRAP_EN
   logic r_misaligned;

   assign w_lane  = w_lane_raw;
   assign w_misal = (w_is_half && w_lane_raw[0]) ||
                    (!w_is_byte && !w_is_half && (w_lane_raw != 2'b00));

   always_ff @(posedge i_clock) begin
      if (i_reset)                  r_misaligned <= 1'b0;
      else if (w_access && w_misal) r_misaligned <= 1'b1;
   end

   assign bus.o_misaligned = r_misaligned;
`else
   assign w_lane  = w_is_byte ? w_lane_raw : (w_is_half ? {w_lane_raw[1], 1'b0} : 2'b00);
   assign w_misal = 1'b0;
   assign bus.o_misaligned = 1'b0;
`endif

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.i_regB;
      if (w_is_byte) begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{bus.i_regB[7:0]}};
      end else if (w_is_half) begin
         w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{bus.i_regB[15:0]}};
      end
   end

   assign w_we = bus.i_start && bus.i_step && bus.i_mem[MEM_WR_BIT] && !w_busy && !w_misal;

   always_comb begin
      w_byte = w_rdata[{w_lane, 3'b000} +: 8];
      w_half = w_rdata[{w_lane[1], 4'b0000} +: 16];
      w_ext  = w_rdata;
      if (w_is_byte)
         w_ext = bus.i_signedmem ? {{(DATA_WIDTH-8){w_byte[7]}}, w_byte}
                                 : {{(DATA_WIDTH-8){1'b0}}, w_byte};
      else if (w_is_half)
         w_ext = bus.i_signedmem ? {{(DATA_WIDTH-16){w_half[15]}}, w_half}
                                 : {{(DATA_WIDTH-16){1'b0}}, w_half};
   end

   assign bus.o_read_data = (bus.i_mem[MEM_RD_BIT] && !w_misal) ? w_ext : '0;

   // Dump FSM: READ fetches one word, SEND holds it until the consumer takes it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_dump_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.i_dump_req) begin
               r_dump_addr <= '0;
               r_state     <= ST_READ;
            end
            ST_READ: r_state <= ST_SEND;
            ST_SEND: if (bus.i_dump_ready) begin
               if (r_dump_addr == LAST_ADDR) begin
                  r_state <= ST_DONE;
               end else begin
                  r_dump_addr <= r_dump_addr + 1'b1;
                  r_state     <= ST_READ;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_busy           = (r_state != ST_IDLE);
   assign bus.o_busy       = w_busy;
   assign bus.o_dump_valid = (r_state == ST_SEND);
   assign bus.o_dump_done  = (r_state == ST_DONE);
   assign bus.o_dump_addr  = r_dump_addr;

   dmem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_we        (w_we),
      .i_be        (w_be),
      .i_addr      (w_widx),
      .i_wdata     (w_wdata),
      .o_rdata     (w_rdata),
      .i_dump_en   (r_state == ST_READ),
      .i_dump_addr (r_dump_addr),
      .o_dump_data (bus.o_dump_data)
   );
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: loads/stores, step gating, dump stream, reset mid-dump.
module tb_mem_stage_dmem;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_stage_dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

   mem_stage_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      bus.i_aluresult = addr;
      bus.i_regB      = data;
      bus.i_sizemem   = size;
      bus.i_mem       = 3'b010;
      bus.i_start     = 1'b1;
      bus.i_step      = 1'b1;
      tick();
      bus.i_mem       = 3'b000;
   endtask

   task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] exp);
      bus.i_aluresult = addr;
      bus.i_sizemem   = size;
      bus.i_signedmem = sgn;
      bus.i_mem       = 3'b001;
      #1;
      chk(tag, bus.o_read_data, exp);
      bus.i_mem       = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] exp_d;
      logic        known;

      bus.i_start = 1'b0;      bus.i_step = 1'b0;
      bus.i_aluresult = '0;    bus.i_regB = '0;
      bus.i_mem = 3'b000;      bus.i_sizemem = SIZE_WORD;
      bus.i_signedmem = 1'b0;  bus.i_dump_req = 1'b0;
      bus.i_dump_ready = 1'b0;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", {31'b0, bus.o_busy}, 32'd0);
      chk("rst_valid", {31'b0, bus.o_dump_valid}, 32'd0);
      chk("rst_addr", {25'b0, bus.o_dump_addr}, 32'd0);
      chk("rst_data", bus.o_dump_data, 32'd0);
      chk("rst_done", {31'b0, bus.o_dump_done}, 32'd0);
      chk("rst_misal", {31'b0, bus.o_misaligned}, 32'd0);
      chk("rd_disabled", bus.o_read_data, 32'd0);

      // Word store then byte loads
      store(32'h10, 32'h8899AABB, SIZE_WORD);
      load_chk("ld_b_signed", 32'h11, SIZE_BYTE, 1'b1, 32'hFFFFFFAA);
      load_chk("ld_b_unsigned", 32'h11, SIZE_BYTE, 1'b0, 32'h000000AA);
      load_chk("ld_w", 32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);
      load_chk("ld_b_hi_signed", 32'h13, SIZE_BYTE, 1'b1, 32'hFFFFFF88);

      // Half store over all-ones word
      store(32'h20, 32'hFFFFFFFF, SIZE_WORD);
      store(32'h22, 32'hABCD1234, SIZE_HALF);
      load_chk("ld_w_after_half", 32'h20, SIZE_WORD, 1'b0, 32'h1234FFFF);
      load_chk("ld_h_signed_hi", 32'h22, SIZE_HALF, 1'b1, 32'h00001234);
      load_chk("ld_h_signed_lo", 32'h20, SIZE_HALF, 1'b1, 32'hFFFFFFFF);
      load_chk("ld_h_unsigned_lo", 32'h20, SIZE_HALF, 1'b0, 32'h0000FFFF);
      store(32'h23, 32'hFFFFFF5A, SIZE_BYTE);
      load_chk("ld_w_after_byte", 32'h20, 2'b11, 1'b0, 32'h5A34FFFF);

      // Upper address bits wrap
      store(32'h230, 32'hCAFEF00D, SIZE_WORD);
      load_chk("ld_wrap", 32'h30, SIZE_WORD, 1'b0, 32'hCAFEF00D);

      // Step / start gating
      store(32'h40, 32'hDEADBEEF, SIZE_WORD);
      bus.i_aluresult = 32'h40; bus.i_regB = 32'h11111111; bus.i_sizemem = SIZE_WORD;
      bus.i_mem = 3'b010; bus.i_start = 1'b1; bus.i_step = 1'b0;
      tick();
      bus.i_start = 1'b0; bus.i_step = 1'b1;
      tick();
      bus.i_mem = 3'b000; bus.i_start = 1'b1;
      load_chk("gated_store", 32'h40, SIZE_WORD, 1'b0, 32'hDEADBEEF);
      store(32'h40, 32'h11111111, SIZE_WORD);
      load_chk("stepped_store", 32'h40, SIZE_WORD, 1'b0, 32'h11111111);

      // Simultaneous read/write sees pre-write contents
      bus.i_aluresult = 32'h40; bus.i_regB = 32'h22222222; bus.i_sizemem = SIZE_WORD;
      bus.i_signedmem = 1'b0; bus.i_mem = 3'b011;
      #1;
      chk("rw_old", bus.o_read_data, 32'h11111111);
      tick();
      bus.i_mem = 3'b001;
      #1;
      chk("rw_new", bus.o_read_data, 32'h22222222);
      bus.i_mem = 3'b000;

      // Dump with ready toggled
      for (int k = 0; k < 4; k++) store(32'(k * 4), 32'(k + 1), SIZE_WORD);
      bus.i_dump_ready = 1'b0;
      bus.i_dump_req = 1'b1;
      tick();
      bus.i_dump_req = 1'b0;
      chk("dump_busy", {31'b0, bus.o_busy}, 32'd1);
      for (int i = 0; i < 128; i++) begin
         n = 0;
         while (!bus.o_dump_valid && n < 8) begin tick(); n++; end
         chk("dump_valid_addr", {24'b0, bus.o_dump_valid, bus.o_dump_addr}, {24'b0, 1'b1, 7'(i)});
         known = 1'b1;
         case (i)
            0: exp_d = 32'd1;   1: exp_d = 32'd2;   2: exp_d = 32'd3;   3: exp_d = 32'd4;
            4: exp_d = 32'h8899AABB;  8: exp_d = 32'h5A34FFFF;
            12: exp_d = 32'hCAFEF00D; 16: exp_d = 32'h22222222;
            default: begin exp_d = '0; known = 1'b0; end
         endcase
         if (known) chk("dump_data", bus.o_dump_data, exp_d);
         if (i == 2) begin
            bus.i_aluresult = 32'h10; bus.i_regB = 32'h77777777; bus.i_sizemem = SIZE_WORD;
            bus.i_mem = 3'b010; bus.i_start = 1'b1; bus.i_step = 1'b1;
         end
         tick();
         bus.i_mem = 3'b000;
         chk("dump_hold", {24'b0, bus.o_dump_valid, bus.o_dump_addr}, {24'b0, 1'b1, 7'(i)});
         if (known) chk("dump_hold_data", bus.o_dump_data, exp_d);
         bus.i_dump_ready = 1'b1;
         tick();
         bus.i_dump_ready = 1'b0;
      end
      chk("dump_done_pulse", {30'b0, bus.o_dump_done, bus.o_busy}, 32'd3);
      tick();
      chk("dump_done_clear", {29'b0, bus.o_dump_done, bus.o_busy, bus.o_dump_valid}, 32'd0);
      load_chk("store_during_dump", 32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);

      // Ready held high: throughput and reset mid-dump
      bus.i_dump_ready = 1'b1;
      bus.i_dump_req = 1'b1;
      tick();
      bus.i_dump_req = 1'b0;
      n = 0;
      while (!(bus.o_dump_valid && bus.o_dump_addr == 7'd5) && n < 50) begin tick(); n++; end
      chk("dump_rate_cycles", 32'(n), 32'd11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_dump", {30'b0, bus.o_dump_valid, bus.o_busy}, 32'd0);
      bus.i_dump_ready = 1'b0;
      load_chk("ram_kept_0", 32'h0, SIZE_WORD, 1'b0, 32'd1);
      load_chk("ram_kept_10", 32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);

      // Misaligned word store
      store(32'h13, 32'h55555555, SIZE_WORD);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("misal_flag", {31'b0, bus.o_misaligned}, 32'd1);
      load_chk("misal_ram_kept", 32'h10, SIZE_WORD, 1'b0, 32'h8899AABB);
      load_chk("misal_load_zero", 32'h13, SIZE_WORD, 1'b0, 32'd0);
      store(32'h20, 32'h0BADF00D, SIZE_WORD);
      chk("misal_sticky", {31'b0, bus.o_misaligned}, 32'd1);
`else
      chk("misal_flag", {31'b0, bus.o_misaligned}, 32'd0);
      load_chk("align_store", 32'h10, SIZE_WORD, 1'b0, 32'h55555555);
      load_chk("align_load", 32'h13, SIZE_WORD, 1'b0, 32'h55555555);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
